// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND flash controller command path: ACG field widths,
// the values the ACG port rests at when nobody owns it, and the arbiter state encoding.
package nfc_pkg;

    localparam int ACG_CMD_W    = 8;
    localparam int ACG_OPT_W    = 3;
    localparam int ACG_NOD_W    = 16;
    localparam int ACG_CASEL_W  = 1;
    localparam int ACG_CADATA_W = 40;

    localparam logic [ACG_CMD_W-1:0]    ACG_CMD_IDLE    = '0;
    localparam logic [ACG_OPT_W-1:0]    ACG_OPT_IDLE    = '0;
    localparam logic [ACG_NOD_W-1:0]    ACG_NOD_IDLE    = '0;
    localparam logic [ACG_CASEL_W-1:0]  ACG_CASEL_IDLE  = 1'b1;
    localparam logic [ACG_CADATA_W-1:0] ACG_CADATA_IDLE = '0;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/nfc_acg_onehot_mux.sv
// AND-OR one-hot mux selecting one slot's field out of a packed per-slot bus.
// Purely combinational; an all-zero select yields zero.
module nfc_acg_onehot_mux #(
    parameter int Width    = 8,
    parameter int NumOfCmd = 4
) (
    input  logic [NumOfCmd-1:0]       sel,
    input  logic [Width*NumOfCmd-1:0] data,
    output logic [Width-1:0]          y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < NumOfCmd; i++) begin
            y = y | (data[i*Width +: Width] & {Width{sel[i]}});
        end
    end

endmodule

// File: rtl/nfc_command_arbiter.sv
// Grants the single ACG port to the lowest-index starting command slot and routes its
// request until that slot's last step; gates host commands while busy, with a watchdog.
module nfc_command_arbiter
    import nfc_pkg::*;
#(
    parameter int          NumberOfWays  = 4,
    parameter int          NumOfCmd      = 4,
    parameter logic [15:0] TimeoutCycles = 16'hFFFF
) (
    input  logic                             iSystemClock,
    input  logic                             iReset,
    input  logic                             iCMDValid,
    output logic                             oCMDReady,
    input  logic [NumOfCmd-1:0]              iCmdCMDReady,
    input  logic [NumOfCmd-1:0]              iCmdStart,
    input  logic [NumOfCmd-1:0]              iCmdLastStep,
    input  logic [ACG_CMD_W*NumOfCmd-1:0]    iCmdACG_Command,
    input  logic [ACG_OPT_W*NumOfCmd-1:0]    iCmdACG_CommandOption,
    input  logic [NumberOfWays*NumOfCmd-1:0] iCmdACG_TargetWay,
    input  logic [ACG_NOD_W*NumOfCmd-1:0]    iCmdACG_NumOfData,
    input  logic [NumOfCmd-1:0]              iCmdACG_CASelect,
    input  logic [ACG_CADATA_W*NumOfCmd-1:0] iCmdACG_CAData,
    output logic [ACG_CMD_W-1:0]             oACG_Command,
    output logic [ACG_OPT_W-1:0]             oACG_CommandOption,
    output logic [NumberOfWays-1:0]          oACG_TargetWay,
    output logic [ACG_NOD_W-1:0]             oACG_NumOfData,
    output logic                             oACG_CASelect,
    output logic [ACG_CADATA_W-1:0]          oACG_CAData,
    output logic [NumOfCmd-1:0]              oOwner,
    output logic                             oLastStep,
    output logic                             oBusy,
    output logic                             oTimeout,
    output logic                             oProtocolError
);

    localparam logic [NumOfCmd-1:0] ONE = NumOfCmd'(1);

    arb_state_t          state, state_nxt;
    logic [NumOfCmd-1:0] owner, owner_nxt;
    logic [15:0]         wd_cnt, wd_cnt_nxt;
    logic                timeout_q, timeout_nxt;
    logic                perr_q, perr_set;

    logic [NumOfCmd-1:0] start_low;
    logic                start_multi;
    logic                owner_last;
    logic                stray_evt;
    logic                wd_hit;
    logic                cmd_valid_unused;

    // Command decode lives in the slots; host valid is only observed here.
    assign cmd_valid_unused = iCMDValid;

    assign start_low   = iCmdStart & (~iCmdStart + ONE);
    assign start_multi = |(iCmdStart & (iCmdStart - ONE));
    assign owner_last  = |(iCmdLastStep & owner);
    assign stray_evt   = |((iCmdStart | iCmdLastStep) & ~owner);
    assign wd_hit      = (wd_cnt >= (TimeoutCycles - 16'd1));

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        wd_cnt_nxt  = wd_cnt;
        timeout_nxt = 1'b0;
        perr_set    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|iCmdStart) begin
                    state_nxt  = ARB_BUSY;
                    owner_nxt  = start_low;
                    wd_cnt_nxt = '0;
                    perr_set   = start_multi;
                end
            end
            ARB_BUSY: begin
                perr_set = stray_evt;
                // A last step in the same cycle as expiry is a normal completion.
                if (owner_last) begin
                    state_nxt = ARB_IDLE;
                    owner_nxt = '0;
                end else if (wd_hit) begin
                    state_nxt   = ARB_IDLE;
                    owner_nxt   = '0;
                    timeout_nxt = 1'b1;
                end else if (wd_cnt != 16'hFFFF) begin
                    wd_cnt_nxt = wd_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                owner_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            wd_cnt    <= wd_cnt_nxt;
            timeout_q <= timeout_nxt;
            perr_q    <= perr_q | perr_set;
        end
    end

    logic [ACG_CMD_W-1:0]    mux_cmd;
    logic [ACG_OPT_W-1:0]    mux_opt;
    logic [NumberOfWays-1:0] mux_way;
    logic [ACG_NOD_W-1:0]    mux_nod;
    logic                    mux_casel;
    logic [ACG_CADATA_W-1:0] mux_cadata;

    nfc_acg_onehot_mux #(.Width(ACG_CMD_W), .NumOfCmd(NumOfCmd)) u_mux_cmd (
        .sel(owner), .data(iCmdACG_Command), .y(mux_cmd));
    nfc_acg_onehot_mux #(.Width(ACG_OPT_W), .NumOfCmd(NumOfCmd)) u_mux_opt (
        .sel(owner), .data(iCmdACG_CommandOption), .y(mux_opt));
    nfc_acg_onehot_mux #(.Width(NumberOfWays), .NumOfCmd(NumOfCmd)) u_mux_way (
        .sel(owner), .data(iCmdACG_TargetWay), .y(mux_way));
    nfc_acg_onehot_mux #(.Width(ACG_NOD_W), .NumOfCmd(NumOfCmd)) u_mux_nod (
        .sel(owner), .data(iCmdACG_NumOfData), .y(mux_nod));
    nfc_acg_onehot_mux #(.Width(ACG_CASEL_W), .NumOfCmd(NumOfCmd)) u_mux_casel (
        .sel(owner), .data(iCmdACG_CASelect), .y(mux_casel));
    nfc_acg_onehot_mux #(.Width(ACG_CADATA_W), .NumOfCmd(NumOfCmd)) u_mux_cadata (
        .sel(owner), .data(iCmdACG_CAData), .y(mux_cadata));

    // Outputs follow the registered state, so reset forces idle values without a clock.
    assign oBusy              = (state == ARB_BUSY);
    assign oOwner             = owner;
    assign oLastStep          = owner_last;
    assign oTimeout           = timeout_q;
    assign oProtocolError     = perr_q;
    assign oCMDReady          = (state == ARB_IDLE) && (&iCmdCMDReady);
    assign oACG_Command       = oBusy ? mux_cmd    : ACG_CMD_IDLE;
    assign oACG_CommandOption = oBusy ? mux_opt    : ACG_OPT_IDLE;
    assign oACG_TargetWay     = oBusy ? mux_way    : '0;
    assign oACG_NumOfData     = oBusy ? mux_nod    : ACG_NOD_IDLE;
    assign oACG_CASelect      = oBusy ? mux_casel  : ACG_CASEL_IDLE;
    assign oACG_CAData        = oBusy ? mux_cadata : ACG_CADATA_IDLE;

endmodule

// File: tb/tb_nfc_command_arbiter.sv
// Directed bench: a default-watchdog instance for routing/protocol checks and a
// short-watchdog instance (16 cycles) for the timeout corner cases, sharing stimulus.
module tb_nfc_command_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [3:0]  cmd_rdy, start, last;
    logic [31:0] f_cmd;
    logic [11:0] f_opt;
    logic [15:0] f_way;
    logic [63:0] f_nod;
    logic [3:0]  f_casel;
    logic [159:0] f_cadata;

    logic        a_rdy, a_casel, a_ls, a_busy, a_tmo, a_err;
    logic [7:0]  a_cmd;
    logic [2:0]  a_opt;
    logic [3:0]  a_way, a_owner;
    logic [15:0] a_nod;
    logic [39:0] a_cadata;

    logic        t_rdy, t_casel, t_ls, t_busy, t_tmo, t_err;
    logic [7:0]  t_cmd;
    logic [2:0]  t_opt;
    logic [3:0]  t_way, t_owner;
    logic [15:0] t_nod;
    logic [39:0] t_cadata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nfc_command_arbiter dut_a (
        .iSystemClock(clk), .iReset(rst), .iCMDValid(cmd_valid), .oCMDReady(a_rdy),
        .iCmdCMDReady(cmd_rdy), .iCmdStart(start), .iCmdLastStep(last),
        .iCmdACG_Command(f_cmd), .iCmdACG_CommandOption(f_opt), .iCmdACG_TargetWay(f_way),
        .iCmdACG_NumOfData(f_nod), .iCmdACG_CASelect(f_casel), .iCmdACG_CAData(f_cadata),
        .oACG_Command(a_cmd), .oACG_CommandOption(a_opt), .oACG_TargetWay(a_way),
        .oACG_NumOfData(a_nod), .oACG_CASelect(a_casel), .oACG_CAData(a_cadata),
        .oOwner(a_owner), .oLastStep(a_ls), .oBusy(a_busy), .oTimeout(a_tmo),
        .oProtocolError(a_err));

    nfc_command_arbiter #(.TimeoutCycles(16'd16)) dut_t (
        .iSystemClock(clk), .iReset(rst), .iCMDValid(cmd_valid), .oCMDReady(t_rdy),
        .iCmdCMDReady(cmd_rdy), .iCmdStart(start), .iCmdLastStep(last),
        .iCmdACG_Command(f_cmd), .iCmdACG_CommandOption(f_opt), .iCmdACG_TargetWay(f_way),
        .iCmdACG_NumOfData(f_nod), .iCmdACG_CASelect(f_casel), .iCmdACG_CAData(f_cadata),
        .oACG_Command(t_cmd), .oACG_CommandOption(t_opt), .oACG_TargetWay(t_way),
        .oACG_NumOfData(t_nod), .oACG_CASelect(t_casel), .oACG_CAData(t_cadata),
        .oOwner(t_owner), .oLastStep(t_ls), .oBusy(t_busy), .oTimeout(t_tmo),
        .oProtocolError(t_err));

    typedef struct {
        logic [3:0] start;
        logic [3:0] last;
        logic [3:0] rdy;
        logic [3:0] owner;
        logic       busy;
        logic       ls;
        logic       cmdrdy;
        logic       err;
        logic       tmo;
        logic [7:0] cmd;
        logic       casel;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = '0;
        last  = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rdy   = 4'hF;
        start     = '0;
        last      = '0;
        for (int i = 0; i < 4; i++) begin
            f_cmd[i*8 +: 8]    = 8'h10 + 8'(i);
            f_opt[i*3 +: 3]    = 3'(i + 1);
            f_way[i*4 +: 4]    = 4'(1 << i);
            f_nod[i*16 +: 16]  = 16'h0100 + 16'(i);
            f_casel[i]         = (i % 2) == 1;
            f_cadata[i*40 +: 40] = 40'h11_1111_1111 * 40'(i + 1);
        end
        f_cadata[80 +: 40] = 40'hFF_0000_0000;

        //            start    last     rdy      owner    bsy   ls    crdy  err   tmo   cmd    casel
        vecs[0] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{4'b0000, 4'b0000, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{4'b0001, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{4'b0000, 4'b0000, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
        vecs[4] = '{4'b0000, 4'b0001, 4'b1111, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
        vecs[5] = '{4'b1000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{4'b0000, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 1'b1};
        vecs[7] = '{4'b1000, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 1'b1};
        vecs[8] = '{4'b0000, 4'b1000, 4'b1111, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h13, 1'b1};
        vecs[9] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};

        do_reset();

        // Cycle-by-cycle table: reset state, ready gating, grant, release, back-to-back.
        for (int v = 0; v < 10; v++) begin
            start   = vecs[v].start;
            last    = vecs[v].last;
            cmd_rdy = vecs[v].rdy;
            #1;
            chk($sformatf("vec%0d", v),
                64'({a_owner, a_busy, a_ls, a_rdy, a_err, a_tmo, a_cmd, a_casel}),
                64'({vecs[v].owner, vecs[v].busy, vecs[v].ls, vecs[v].cmdrdy,
                     vecs[v].err, vecs[v].tmo, vecs[v].cmd, vecs[v].casel}));
            @(negedge clk);
        end
        start = '0;
        last  = '0;

        // Slot 2 owns the port for 40 cycles.
        do_reset();
        start = 4'b0100;
        @(negedge clk);
        start = '0;
        #1;
        chk("slot2_fields", 64'({a_cmd, a_opt, a_way, a_nod}),
            64'({8'h12, 3'd3, 4'b0100, 16'h0102}));
        for (int k = 1; k <= 40; k++) begin
            if (k == 40) last = 4'b0100;
            #1;
            chk($sformatf("slot2_cyc%0d", k),
                64'({a_owner, a_busy, a_rdy, a_ls, a_cadata}),
                64'({4'b0100, 1'b1, 1'b0, (k == 40), 40'hFF_0000_0000}));
            @(negedge clk);
        end
        last = '0;
        #1;
        chk("slot2_release", 64'({a_owner, a_busy, a_rdy, a_cadata}),
            64'({4'b0000, 1'b0, 1'b1, 40'h0}));

        // Simultaneous starts: lowest index wins, error is sticky.
        do_reset();
        start = 4'b1010;
        @(negedge clk);
        start = '0;
        #1;
        chk("multi_grant", 64'({a_owner, a_err}), 64'({4'b0010, 1'b1}));
        last = 4'b0010;
        @(negedge clk);
        last = '0;
        #1;
        chk("multi_release", 64'({a_busy, a_err}), 64'({1'b0, 1'b1}));
        @(negedge clk);
        #1;
        chk("multi_sticky", 64'(a_err), 64'(1'b1));

        // Non-owner last step is ignored but flagged.
        do_reset();
        chk("err_cleared", 64'(a_err), 64'(1'b0));
        start = 4'b0001;
        @(negedge clk);
        start = '0;
        last  = 4'b0010;
        #1;
        chk("stray_ls_out", 64'(a_ls), 64'(1'b0));
        @(negedge clk);
        last = '0;
        #1;
        chk("stray_hold", 64'({a_owner, a_busy, a_err}), 64'({4'b0001, 1'b1, 1'b1}));
        last = 4'b0001;
        @(negedge clk);
        last = '0;
        #1;
        chk("stray_release", 64'({a_owner, a_busy, a_err}), 64'({4'b0000, 1'b0, 1'b1}));

        // Watchdog expiry on the 16-cycle instance.
        do_reset();
        start = 4'b0010;
        @(negedge clk);
        start = '0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk($sformatf("wd_busy%0d", k), 64'({t_busy, t_tmo}), 64'({1'b1, 1'b0}));
            @(negedge clk);
        end
        #1;
        chk("wd_fire", 64'({t_tmo, t_busy, t_owner, t_cmd, t_casel}),
            64'({1'b1, 1'b0, 4'b0000, 8'h00, 1'b1}));
        @(negedge clk);
        #1;
        chk("wd_pulse_end", 64'(t_tmo), 64'(1'b0));

        // Last step in the expiry cycle completes normally.
        do_reset();
        start = 4'b0010;
        @(negedge clk);
        start = '0;
        for (int k = 1; k < 16; k++) @(negedge clk);
        last = 4'b0010;
        #1;
        chk("wd_tie_ls", 64'({t_busy, t_ls}), 64'({1'b1, 1'b1}));
        @(negedge clk);
        last = '0;
        #1;
        chk("wd_tie_done", 64'({t_tmo, t_busy}), 64'({1'b0, 1'b0}));

        // Asynchronous reset in the middle of a command.
        do_reset();
        start = 4'b1000;
        @(negedge clk);
        start = '0;
        #1;
        chk("arst_pre", 64'({a_busy, a_cmd}), 64'({1'b1, 8'h13}));
        rst = 1'b1;
        #1;
        chk("arst_now", 64'({a_busy, a_owner, a_cmd, a_casel}),
            64'({1'b0, 4'b0000, 8'h00, 1'b1}));
        rst = 1'b0;
        #1;
        start = 4'b0001;
        @(negedge clk);
        start = '0;
        #1;
        chk("arst_restart", 64'({a_busy, a_owner}), 64'({1'b1, 4'b0001}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
